// File: rtl/axis_pup_loop_pkg.sv
// Shared types and constants for the packer/unpacker loopback controller.
package axis_pup_loop_pkg;

   typedef enum logic [1:0] {
      NORMAL,
      DRAIN_TO_LOOP,
      LOOP,
      DRAIN_TO_NORMAL
   } loop_state_t;

   localparam int unsigned STATS_CNT_W = 32;

   function automatic logic [STATS_CNT_W-1:0] sat_inc(input logic [STATS_CNT_W-1:0] v);
      return (v == '1) ? v : v + STATS_CNT_W'(1);
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock AXIS FIFO holding tdata/tkeep/tlast; ready and valid are registered.
module axis_sync_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  logic [DATA_WIDTH-1:0]   in_tdata,
   input  logic [DATA_WIDTH/8-1:0] in_tkeep,
   input  logic                    in_tlast,
   input  logic                    in_tvalid,
   output logic                    in_tready,
   output logic [DATA_WIDTH-1:0]   out_tdata,
   output logic [DATA_WIDTH/8-1:0] out_tkeep,
   output logic                    out_tlast,
   output logic                    out_tvalid,
   input  logic                    out_tready
);

   localparam int unsigned KW = DATA_WIDTH / 8;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned WW = DATA_WIDTH + KW + 1;

   logic [WW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nx;
   logic          push;
   logic          pop;

   always_comb begin
      push     = in_tvalid & in_tready;
      pop      = out_tvalid & out_tready;
      count_nx = count + CW'(push) - CW'(pop);
   end

   // Flags are computed from the next count so they are registered yet never stale.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         in_tready  <= 1'b0;
         out_tvalid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count      <= count_nx;
         in_tready  <= (count_nx != CW'(FIFO_DEPTH));
         out_tvalid <= (count_nx != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_tlast, in_tkeep, in_tdata};
   end

   assign {out_tlast, out_tkeep, out_tdata} = mem[rd_ptr];

endmodule

// File: rtl/axis_pup_loop_ctrl.sv
// Routes an AXIS stream through packer/unpacker or a local loopback, switching only on packet boundaries.
// Optional packet statistics are enabled by defining AXIS_PUP_LOOP_STATS_EN.
module axis_pup_loop_ctrl
   import axis_pup_loop_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  logic                    loop_req,
   output logic                    loop_active,
   output logic                    switch_busy,
`ifdef AXIS_PUP_LOOP_STATS_EN
   input  logic                    stats_clr,
   output logic [STATS_CNT_W-1:0]  loop_pkt_cnt,
   output logic [STATS_CNT_W-1:0]  norm_pkt_cnt,
`endif
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tlast,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [DATA_WIDTH-1:0]   packer_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] packer_axis_tkeep,
   output logic                    packer_axis_tlast,
   output logic                    packer_axis_tvalid,
   input  logic                    packer_axis_tready,
   input  logic [DATA_WIDTH-1:0]   unpacker_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] unpacker_axis_tkeep,
   input  logic                    unpacker_axis_tlast,
   input  logic                    unpacker_axis_tvalid,
   output logic                    unpacker_axis_tready
);

   localparam int unsigned KW = DATA_WIDTH / 8;

   loop_state_t     state;
   logic            pk_open;
   logic            up_open;
   logic            lp_open;

   logic [DATA_WIDTH-1:0] if_tdata;
   logic [KW-1:0]         if_tkeep;
   logic                  if_tlast;
   logic                  if_tvalid;
   logic                  if_tready;

   logic [DATA_WIDTH-1:0] of_tdata;
   logic [KW-1:0]         of_tkeep;
   logic                  of_tlast;
   logic                  of_tvalid;
   logic                  of_tready;

   logic pk_fwd, up_fwd, lp_fwd;
   logic pk_xfer, up_xfer, lp_xfer;

   axis_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_in_fifo (
      .clk        (clk),
      .arst_n     (arst_n),
      .in_tdata   (s_axis_tdata),
      .in_tkeep   (s_axis_tkeep),
      .in_tlast   (s_axis_tlast),
      .in_tvalid  (s_axis_tvalid),
      .in_tready  (s_axis_tready),
      .out_tdata  (if_tdata),
      .out_tkeep  (if_tkeep),
      .out_tlast  (if_tlast),
      .out_tvalid (if_tvalid),
      .out_tready (if_tready)
   );

   axis_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk        (clk),
      .arst_n     (arst_n),
      .in_tdata   (of_tdata),
      .in_tkeep   (of_tkeep),
      .in_tlast   (of_tlast),
      .in_tvalid  (of_tvalid),
      .in_tready  (of_tready),
      .out_tdata  (m_axis_tdata),
      .out_tkeep  (m_axis_tkeep),
      .out_tlast  (m_axis_tlast),
      .out_tvalid (m_axis_tvalid),
      .out_tready (m_axis_tready)
   );

   // A path keeps forwarding during a drain only while its packet is still open.
   always_comb begin
      pk_fwd = (state == NORMAL) || ((state == DRAIN_TO_LOOP) && pk_open);
      up_fwd = (state == NORMAL) || ((state == DRAIN_TO_LOOP) && up_open);
      lp_fwd = (state == LOOP) || ((state == DRAIN_TO_NORMAL) && lp_open);

      packer_axis_tdata    = if_tdata;
      packer_axis_tkeep    = if_tkeep;
      packer_axis_tlast    = if_tlast;
      packer_axis_tvalid   = 1'b0;
      unpacker_axis_tready = 1'b0;
      if_tready            = 1'b0;
      of_tdata             = unpacker_axis_tdata;
      of_tkeep             = unpacker_axis_tkeep;
      of_tlast             = unpacker_axis_tlast;
      of_tvalid            = 1'b0;

      if (pk_fwd) begin
         packer_axis_tvalid = if_tvalid;
         if_tready          = packer_axis_tready;
      end
      if (lp_fwd) begin
         of_tdata  = if_tdata;
         of_tkeep  = if_tkeep;
         of_tlast  = if_tlast;
         of_tvalid = if_tvalid;
         if_tready = of_tready;
      end else if (up_fwd) begin
         of_tvalid            = unpacker_axis_tvalid;
         unpacker_axis_tready = of_tready;
      end

      pk_xfer = packer_axis_tvalid & packer_axis_tready;
      up_xfer = unpacker_axis_tvalid & unpacker_axis_tready;
      lp_xfer = lp_fwd & if_tvalid & of_tready;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         pk_open <= 1'b0;
         up_open <= 1'b0;
         lp_open <= 1'b0;
      end else begin
         if (pk_xfer) pk_open <= !if_tlast;
         if (up_xfer) up_open <= !unpacker_axis_tlast;
         if (lp_xfer) lp_open <= !if_tlast;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= NORMAL;
         loop_active <= 1'b0;
         switch_busy <= 1'b0;
      end else begin
         case (state)
            NORMAL: begin
               if (loop_req) begin
                  state       <= DRAIN_TO_LOOP;
                  switch_busy <= 1'b1;
               end
            end
            DRAIN_TO_LOOP: begin
               if (!pk_open && !up_open) begin
                  state       <= LOOP;
                  switch_busy <= 1'b0;
                  loop_active <= 1'b1;
               end
            end
            LOOP: begin
               if (!loop_req) begin
                  state       <= DRAIN_TO_NORMAL;
                  loop_active <= 1'b0;
                  switch_busy <= 1'b1;
               end
            end
            DRAIN_TO_NORMAL: begin
               if (!lp_open) begin
                  state       <= NORMAL;
                  switch_busy <= 1'b0;
               end
            end
            default: begin
               state       <= NORMAL;
               loop_active <= 1'b0;
               switch_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef AXIS_PUP_LOOP_STATS_EN
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         loop_pkt_cnt <= '0;
         norm_pkt_cnt <= '0;
      end else if (stats_clr) begin
         loop_pkt_cnt <= '0;
         norm_pkt_cnt <= '0;
      end else begin
         if (lp_xfer && if_tlast)             loop_pkt_cnt <= sat_inc(loop_pkt_cnt);
         if (up_xfer && unpacker_axis_tlast)  norm_pkt_cnt <= sat_inc(norm_pkt_cnt);
      end
   end
`endif

endmodule
